// File: rtl/sofa_plus_io_bank_cfg.sv
// -----------------------------------------------------------------------------
// sofa_plus_io_bank_cfg
//
// N-channel IO bank with a shadowed configuration scan chain. Each channel has
// CFG_W configuration bits: bit0 = output enable (en), bit1 = input invert (inv).
// Bits shift into a shadow register (sr). The active configuration is replaced
// only when a load ends after exactly L = NUM_IO*CFG_W shifts. Malformed loads
// are rejected, and the previous configuration keeps driving the pads.
// Everything runs in the programming-clock domain.
//
// Ports
//   prog_clk                        in   configuration clock, rising edge
//   pReset_n                        in   asynchronous active-low reset
//   config_enable                   in   chain shift enable
//   ccff_head                       in   chain serial input
//   ccff_tail                       out  chain serial output (registered)
//   IO_ISOL_N                       in   active-low isolation, 0 = pads safe
//   gfpga_pad_sofa_plus_io_SOC_IN   in   [NUM_IO] pad input from SoC
//   gfpga_pad_sofa_plus_io_SOC_OUT  out  [NUM_IO] pad output to SoC
//   gfpga_pad_sofa_plus_io_SOC_DIR  out  [NUM_IO] 1 = channel drives the pad
//   iopad_outpad                    in   [NUM_IO] fabric data toward the pad
//   iopad_inpad                     out  [NUM_IO] pad data toward the fabric
//   cfg_valid                       out  a good load has committed since reset
//   cfg_error                       out  last commit attempt was rejected (sticky)
//   cfg_busy                        out  load FSM is not idle
// -----------------------------------------------------------------------------
module sofa_plus_io_bank_cfg #(
  parameter int NUM_IO = 8,
  parameter int CFG_W  = 2,
  parameter int CNT_W  = $clog2(NUM_IO * CFG_W + 2)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              config_enable,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              IO_ISOL_N,
  input  logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_DIR,
  input  logic [NUM_IO-1:0] iopad_outpad,
  output logic [NUM_IO-1:0] iopad_inpad,
  output logic              cfg_valid,
  output logic              cfg_error,
  output logic              cfg_busy
);

  localparam int L = NUM_IO * CFG_W;
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(L + 1);  // overrun marker
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [L-1:0]     sr;
  logic [L-1:0]     active;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             shift_en;
  logic             commit;
  logic             reject;

  // Bit counter increment that sticks at L+1. Once saturated, any longer
  // load still reads as "too long" no matter how many extra bits arrive.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_MAX) return CNT_MAX;
    return v + CNT_ONE;
  endfunction

  // Control: next state, counter and the commit/reject decision
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_en   = 1'b0;
    commit     = 1'b0;
    reject     = 1'b0;
    unique case (state)
      IDLE: begin
        if (config_enable) begin
          shift_en   = 1'b1;
          cnt_next   = CNT_ONE;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (config_enable) begin
          shift_en = 1'b1;
          cnt_next = sat_inc(cnt);
        end else begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        // sr is frozen for this cycle. A bit presented now is dropped, and
        // the next load counts from zero.
        commit     = (cnt == CNT_LEN);
        reject     = ~commit;
        cnt_next   = '0;
        state_next = config_enable ? SHIFT : IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Registers: FSM state, shadow chain, bit counter, active configuration
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      ccff_tail <= 1'b0;
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (shift_en) begin
        sr        <= {sr[L-2:0], ccff_head};
        ccff_tail <= sr[L-1];
      end
      if (commit) begin
        active    <= sr;
        cfg_valid <= 1'b1;
        cfg_error <= 1'b0;
      end else if (reject) begin
        cfg_error <= 1'b1;
      end
    end
  end

  assign cfg_busy = (state != IDLE);

  // Pad datapath: combinational from the active configuration and isolation
  always_comb begin
    gfpga_pad_sofa_plus_io_SOC_DIR = '0;
    gfpga_pad_sofa_plus_io_SOC_OUT = '0;
    iopad_inpad                    = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      gfpga_pad_sofa_plus_io_SOC_DIR[i] = active[CFG_W*i] & IO_ISOL_N;
      gfpga_pad_sofa_plus_io_SOC_OUT[i] = iopad_outpad[i] & active[CFG_W*i] & IO_ISOL_N;
      // Output-mode channels return 0 to the fabric.
      iopad_inpad[i] = IO_ISOL_N & ~active[CFG_W*i] &
                       (gfpga_pad_sofa_plus_io_SOC_IN[i] ^ active[CFG_W*i+1]);
    end
  end

endmodule

// File: tb/tb_sofa_plus_io_bank_cfg.sv
// -----------------------------------------------------------------------------
// tb_sofa_plus_io_bank_cfg
//
// Self-checking bench for sofa_plus_io_bank_cfg with NUM_IO=8 (L=16).
// The bench pushes expected post-commit state into a queue when a load is
// driven. It pops and compares that state two edges after config_enable falls.
// A vector table covers the pad datapath with 16'hA5C3 active (en mask 0x39,
// inv mask 0xC9).
// -----------------------------------------------------------------------------
module tb_sofa_plus_io_bank_cfg;

  localparam int NUM_IO = 8;
  localparam int L      = 16;

  logic              prog_clk = 1'b0;
  logic              pReset_n;
  logic              config_enable;
  logic              ccff_head;
  logic              ccff_tail;
  logic              IO_ISOL_N;
  logic [NUM_IO-1:0] soc_in;
  logic [NUM_IO-1:0] soc_out;
  logic [NUM_IO-1:0] soc_dir;
  logic [NUM_IO-1:0] iopad_outpad;
  logic [NUM_IO-1:0] iopad_inpad;
  logic              cfg_valid;
  logic              cfg_error;
  logic              cfg_busy;

  sofa_plus_io_bank_cfg #(.NUM_IO(NUM_IO), .CFG_W(2)) dut (
    .prog_clk                       (prog_clk),
    .pReset_n                       (pReset_n),
    .config_enable                  (config_enable),
    .ccff_head                      (ccff_head),
    .ccff_tail                      (ccff_tail),
    .IO_ISOL_N                      (IO_ISOL_N),
    .gfpga_pad_sofa_plus_io_SOC_IN  (soc_in),
    .gfpga_pad_sofa_plus_io_SOC_OUT (soc_out),
    .gfpga_pad_sofa_plus_io_SOC_DIR (soc_dir),
    .iopad_outpad                   (iopad_outpad),
    .iopad_inpad                    (iopad_inpad),
    .cfg_valid                      (cfg_valid),
    .cfg_error                      (cfg_error),
    .cfg_busy                       (cfg_busy)
  );

  always #5 prog_clk = ~prog_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dir;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       isol_n;
    logic [7:0] soc_in;
    logic [7:0] outpad;
    logic [7:0] exp_out;
    logic [7:0] exp_dir;
    logic [7:0] exp_inpad;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Shift nbits of word MSB first, drop enable, then check the CHECK cycle
  // and the post-commit state popped from the scoreboard.
  task automatic load(input logic [31:0] word, input int nbits,
                      input logic [7:0] exp_dir, input logic exp_valid,
                      input logic exp_err, input logic [7:0] pre_dir,
                      input string name);
    exp_t e;
    e.dir = exp_dir; e.valid = exp_valid; e.err = exp_err;
    sb.push_back(e);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge prog_clk);
      config_enable = 1'b1;
      ccff_head     = word[i];
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    @(negedge prog_clk);
    chk({name, "_check_busy"}, 32'(cfg_busy), 32'd1);
    chk({name, "_precommit_dir"}, 32'(soc_dir), 32'(pre_dir));
    @(negedge prog_clk);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_dir"}, 32'(soc_dir), 32'(e.dir));
      chk({name, "_valid"}, 32'(cfg_valid), 32'(e.valid));
      chk({name, "_error"}, 32'(cfg_error), 32'(e.err));
      chk({name, "_idle"}, 32'(cfg_busy), 32'd0);
    end
  endtask

  logic [23:0] pat;
  logic [15:0] w;

  initial begin
    vecs[0] = '{1'b1, 8'h00, 8'hFF, 8'h39, 8'h39, 8'hC0};
    vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h39, 8'h06};
    vecs[2] = '{1'b1, 8'h0F, 8'h0F, 8'h09, 8'h39, 8'hC6};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 8'hAA, 8'h55, 8'h11, 8'h39, 8'h42};
    vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};

    // Reset with inputs toggling
    pReset_n      = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    IO_ISOL_N     = 1'b1;
    soc_in        = 8'hFF;
    iopad_outpad  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      config_enable = ~config_enable;
      ccff_head     = ~ccff_head;
    end
    #1;
    chk("rst_dir", 32'(soc_dir), 32'h00);
    chk("rst_out", 32'(soc_out), 32'h00);
    chk("rst_valid", 32'(cfg_valid), 32'd0);
    chk("rst_error", 32'(cfg_error), 32'd0);
    chk("rst_tail", 32'(ccff_tail), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_inpad", 32'(iopad_inpad), 32'hFF);
    @(negedge prog_clk);
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    pReset_n      = 1'b1;
    soc_in        = 8'h00;

    // Good, short, long and good again
    load(32'hA5C3, 16, 8'h39, 1'b1, 1'b0, 8'h00, "good_a5c3");
    #1 chk("good_inpad", 32'(iopad_inpad), 32'hC0);
    load(32'hFFFF, 15, 8'h39, 1'b1, 1'b1, 8'h39, "short");
    load(32'h1FFFF, 17, 8'h39, 1'b1, 1'b1, 8'h39, "long");
    load(32'h0001, 16, 8'h01, 1'b1, 1'b0, 8'h39, "good_0001");

    // Pad datapath table with A5C3 active
    load(32'hA5C3, 16, 8'h39, 1'b1, 1'b0, 8'h01, "reload_a5c3");
    foreach (vecs[k]) begin
      @(negedge prog_clk);
      IO_ISOL_N    = vecs[k].isol_n;
      soc_in       = vecs[k].soc_in;
      iopad_outpad = vecs[k].outpad;
      #1;
      chk($sformatf("vec%0d_dir", k), 32'(soc_dir), 32'(vecs[k].exp_dir));
      chk($sformatf("vec%0d_out", k), 32'(soc_out), 32'(vecs[k].exp_out));
      chk($sformatf("vec%0d_inpad", k), 32'(iopad_inpad), 32'(vecs[k].exp_inpad));
    end
    @(negedge prog_clk);
    IO_ISOL_N = 1'b1;
    #1 chk("isol_restore_dir", 32'(soc_dir), 32'h39);

    // Reset in the middle of a load
    for (int i = 0; i < 8; i++) begin
      @(negedge prog_clk);
      config_enable = 1'b1;
      ccff_head     = 1'b1;
    end
    @(negedge prog_clk);
    pReset_n = 1'b0;
    #1;
    chk("midrst_dir", 32'(soc_dir), 32'h00);
    chk("midrst_out", 32'(soc_out), 32'h00);
    chk("midrst_valid", 32'(cfg_valid), 32'd0);
    chk("midrst_error", 32'(cfg_error), 32'd0);
    chk("midrst_busy", 32'(cfg_busy), 32'd0);
    chk("midrst_tail", 32'(ccff_tail), 32'd0);
    @(negedge prog_clk);
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    @(negedge prog_clk);
    pReset_n = 1'b1;

    // Back-to-back: enable reasserted in the CHECK cycle with a 1 on the head
    w = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      @(negedge prog_clk);
      config_enable = 1'b1;
      ccff_head     = w[i];
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    @(negedge prog_clk);
    chk("b2b_in_check", 32'(cfg_busy), 32'd1);
    chk("b2b_precommit_dir", 32'(soc_dir), 32'h00);
    config_enable = 1'b1;
    ccff_head     = 1'b1;
    @(negedge prog_clk);
    chk("b2b_commit_dir", 32'(soc_dir), 32'h39);
    chk("b2b_commit_valid", 32'(cfg_valid), 32'd1);
    chk("b2b_busy_shift", 32'(cfg_busy), 32'd1);
    w = 16'h0001;
    for (int i = 15; i >= 0; i--) begin
      if (i != 15) @(negedge prog_clk);
      config_enable = 1'b1;
      ccff_head     = w[i];
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    @(negedge prog_clk);
    @(negedge prog_clk);
    chk("b2b_second_dir", 32'(soc_dir), 32'h01);
    chk("b2b_second_error", 32'(cfg_error), 32'd0);

    // Passthrough: tail after shift edge j+L carries the bit of shift edge j
    pat = 24'hB4E1D2;
    for (int k = 0; k <= 24; k++) begin
      @(negedge prog_clk);
      if (k >= L + 1)
        chk($sformatf("tail_%0d", k - 1 - L), 32'(ccff_tail), 32'(pat[23 - (k - 1 - L)]));
      if (k < 24) begin
        config_enable = 1'b1;
        ccff_head     = pat[23 - k];
      end else begin
        config_enable = 1'b0;
        ccff_head     = 1'b0;
      end
    end
    @(negedge prog_clk);
    @(negedge prog_clk);
    chk("overrun_error", 32'(cfg_error), 32'd1);
    chk("overrun_dir_kept", 32'(soc_dir), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
